// File: rtl/trng_uart_tx.sv
// trng_uart_tx: UART transmit stage downstream of the TRNG byte FIFO.
//
// This block takes one byte per write handshake into a holding register.
// It sends the byte as 8N1 or 8N2, least significant bit first. A new start
// bit is sent only while the host's RTS (active low) is asserted.
// RTS is only sampled at byte boundaries, so a byte that has begun always
// finishes with its normal timing. Each START entry advances a frame
// counter. The first byte of every frame of FRAME_BYTES bytes raises a
// one-cycle marker.
//
// Ports:
//   i_clk           system clock
//   i_reset         synchronous, active-high reset
//   i_dat[7:0]      byte to transmit
//   i_write         write strobe; accepted only while o_ready=1
//   i_serial_rts_n  host RTS, active low, asynchronous to i_clk
//   o_ready         holding register empty; a write is accepted this cycle
//   o_serial_data   UART TX line; idles at 1
//   o_new_frame     one-cycle pulse when the first byte of a frame starts
//   o_busy          shifter not in IDLE (includes waiting for RTS)

module trng_uart_tx #(
   parameter int CLK_DIV     = 104,  // i_clk cycles per serial bit, 2..65535
   parameter int FRAME_BYTES = 16,   // bytes per frame, 1..256
   parameter int STOP_BITS   = 1     // 1 or 2
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [7:0] i_dat,
   input  logic       i_write,
   input  logic       i_serial_rts_n,
   output logic       o_ready,
   output logic       o_serial_data,
   output logic       o_new_frame,
   output logic       o_busy
);

   localparam int BW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int FW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

   localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLK_DIV - 1);
   localparam logic [FW-1:0] FRAME_LAST  = FW'(FRAME_BYTES - 1);
   localparam logic          STOP_LAST   = (STOP_BITS == 2);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_RTS,
      START,
      DATA,
      STOP
   } state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [2:0]      bit_q, bit_d;
   logic            stop_q, stop_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      hold_q, hold_d;
   logic            full_q, full_d;
   logic            line_q, line_d;
   logic [FW-1:0]   frame_q, frame_d;
   logic            new_frame_q, new_frame_d;
   logic            rts_meta_q, rts_sync_q;
   logic            clear_to_send;
   logic            baud_zero;
   logic            load;

   assign clear_to_send = ~rts_sync_q;
   assign baud_zero     = (baud_q == '0);

   // NOTE: every signal driven here gets a default before the case statement.
   // A path that leaves one unassigned would infer a latch.
   always_comb begin
      state_d     = state_q;
      baud_d      = baud_q;
      bit_d       = bit_q;
      stop_d      = stop_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      full_d      = full_q;
      line_d      = line_q;
      frame_d     = frame_q;
      new_frame_d = 1'b0;
      load        = 1'b0;

      // A write while the holding register is full is silently dropped.
      if (i_write && !full_q) begin
         hold_d = i_dat;
         full_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (full_q) begin
               if (clear_to_send) load = 1'b1;
               else               state_d = WAIT_RTS;
            end
         end
         WAIT_RTS: begin
            if (clear_to_send) load = 1'b1;
         end
         START: begin
            if (baud_zero) begin
               state_d = DATA;
               baud_d  = BAUD_RELOAD;
               bit_d   = 3'd0;
               line_d  = shift_q[0];
               shift_d = shift_q >> 1;
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         DATA: begin
            if (baud_zero) begin
               baud_d = BAUD_RELOAD;
               if (bit_q == 3'd7) begin
                  state_d = STOP;
                  stop_d  = 1'b0;
                  line_d  = 1'b1;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  line_d  = shift_q[0];
                  shift_d = shift_q >> 1;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         STOP: begin
            if (baud_zero) begin
               if (stop_q == STOP_LAST) begin
                  // A byte already held when the stop bit ends starts at once.
                  // No idle cycle is inserted.
                  if (full_q && clear_to_send) load = 1'b1;
                  else if (full_q)             state_d = WAIT_RTS;
                  else                         state_d = IDLE;
               end else begin
                  stop_d = 1'b1;
                  baud_d = BAUD_RELOAD;
               end
            end else begin
               baud_d = baud_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Shifter load: empty the holding register, start the start bit and
      // advance the frame counter, all on the same edge.
      if (load) begin
         state_d     = START;
         shift_d     = hold_q;
         full_d      = 1'b0;
         line_d      = 1'b0;
         baud_d      = BAUD_RELOAD;
         new_frame_d = (frame_q == '0);
         frame_d     = (frame_q == FRAME_LAST) ? '0 : frame_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments. All flops then
   // update together from the values sampled before the edge.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q     <= IDLE;
         baud_q      <= '0;
         bit_q       <= 3'd0;
         stop_q      <= 1'b0;
         full_q      <= 1'b0;
         line_q      <= 1'b1;
         frame_q     <= '0;
         new_frame_q <= 1'b0;
         rts_meta_q  <= 1'b1;
         rts_sync_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         baud_q      <= baud_d;
         bit_q       <= bit_d;
         stop_q      <= stop_d;
         full_q      <= full_d;
         line_q      <= line_d;
         frame_q     <= frame_d;
         new_frame_q <= new_frame_d;
         rts_meta_q  <= i_serial_rts_n;
         rts_sync_q  <= rts_meta_q;
      end
   end

   // NOTE: the byte registers carry no reset. Their contents are only used
   // while full_q or the FSM state says they are valid, so resetting the
   // control flops is enough to discard them.
   always_ff @(posedge i_clk) begin
      hold_q  <= hold_d;
      shift_q <= shift_d;
   end

   assign o_ready       = ~full_q;
   assign o_serial_data = line_q;
   assign o_new_frame   = new_frame_q;
   assign o_busy        = (state_q != IDLE);

endmodule

// File: tb/tb_trng_uart_tx.sv
// tb_trng_uart_tx: directed bench for trng_uart_tx.
// Configuration: CLK_DIV=4, FRAME_BYTES=3, STOP_BITS=1.
// Inputs change and outputs are sampled on the falling clock edge.

module tb_trng_uart_tx;

   localparam int CLK_DIV     = 4;
   localparam int FRAME_BYTES = 3;
   localparam int STOP_BITS   = 1;
   localparam int FRAME_CYC   = 10 * CLK_DIV;
   localparam int NONE        = -100;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] dat;
   logic       write;
   logic       rts_n;
   logic       ready;
   logic       serial_data;
   logic       new_frame;
   logic       busy;

   int total = 0;
   int bad   = 0;

   trng_uart_tx #(
      .CLK_DIV    (CLK_DIV),
      .FRAME_BYTES(FRAME_BYTES),
      .STOP_BITS  (STOP_BITS)
   ) dut (
      .i_clk         (clk),
      .i_reset       (reset),
      .i_dat         (dat),
      .i_write       (write),
      .i_serial_rts_n(rts_n),
      .o_ready       (ready),
      .o_serial_data (serial_data),
      .o_new_frame   (new_frame),
      .o_busy        (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag);
      check($sformatf("%s_line", tag), serial_data, 1);
      check($sformatf("%s_busy", tag), busy, 0);
      check($sformatf("%s_ready", tag), ready, 1);
   endtask

   task automatic check_waiting(input string tag);
      check($sformatf("%s_line", tag), serial_data, 1);
      check($sformatf("%s_busy", tag), busy, 1);
      check($sformatf("%s_ready", tag), ready, 0);
   endtask

   // One accepted write from an idle shifter. The byte is held for exactly
   // one cycle (o_ready low, line still 1) before the load edge.
   task automatic send_write(input string tag, input logic [7:0] d);
      dat   = d;
      write = 1'b1;
      tick();
      check($sformatf("%s_ready_low", tag), ready, 0);
      check($sformatf("%s_pre_start_line", tag), serial_data, 1);
      write = 1'b0;
      tick();
   endtask

   // Checks the first ncyc cycles of a frame, starting at the first cycle of
   // the start bit. It can also queue another write at inj_cyc, attempt a
   // dropped overwrite on the cycle after it, and raise RTS at rts_cyc.
   task automatic check_frame(input string tag, input logic [7:0] d, input logic exp_nf,
                              input int ncyc, input int inj_cyc, input logic [7:0] inj_dat,
                              input int drop_en, input logic [7:0] drop_dat, input int rts_cyc);
      for (int c = 0; c < ncyc; c++) begin
         int   k;
         logic exp_bit;
         k = c / CLK_DIV;
         if (k == 0)      exp_bit = 1'b0;
         else if (k == 9) exp_bit = 1'b1;
         else             exp_bit = d[k-1];
         check($sformatf("%s_line_c%0d", tag, c), serial_data, exp_bit);
         check($sformatf("%s_busy_c%0d", tag, c), busy, 1);
         if (c == 0) begin
            check($sformatf("%s_ready_after_load", tag), ready, 1);
            check($sformatf("%s_new_frame", tag), new_frame, exp_nf);
         end
         if (c == 1) check($sformatf("%s_new_frame_width", tag), new_frame, 0);
         if (c == inj_cyc) begin
            dat   = inj_dat;
            write = 1'b1;
         end
         if (c == inj_cyc + 1) begin
            check($sformatf("%s_held_ready_low", tag), ready, 0);
            if (drop_en != 0) dat = drop_dat;
            else              write = 1'b0;
         end
         if (c == inj_cyc + 2) write = 1'b0;
         if (c == rts_cyc) rts_n = 1'b1;
         tick();
      end
   endtask

   logic [7:0] t5_bytes [7];

   initial begin
      reset = 1'b1;
      write = 1'b0;
      dat   = 8'h00;
      rts_n = 1'b0;
      t5_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'h66, 8'h81};

      // Reset state
      tick();
      check("rst_line", serial_data, 1);
      check("rst_ready", ready, 1);
      check("rst_busy", busy, 0);
      check("rst_new_frame", new_frame, 0);
      tick();
      reset = 1'b0;
      repeat (4) begin
         tick();
         check_idle("post_rst");
      end

      // 1: single byte 0xA5, first byte of a frame
      send_write("t1", 8'hA5);
      check_frame("t1", 8'hA5, 1'b1, FRAME_CYC, NONE, 8'h00, 0, 8'h00, NONE);
      check_idle("t1_end");

      // 2: byte queued while shifting, overwrite attempt dropped, no gap
      send_write("t2a", 8'h96);
      check_frame("t2a", 8'h96, 1'b0, FRAME_CYC, 10, 8'h01, 1, 8'hFF, NONE);
      check_frame("t2b", 8'h01, 1'b0, FRAME_CYC, NONE, 8'h00, 0, 8'h00, NONE);
      repeat (5) begin
         check_idle("t2_dropped");
         tick();
      end

      // 3: RTS high holds the byte in WAIT_RTS; start 3 cycles after RTS drops
      rts_n = 1'b1;
      repeat (3) tick();
      send_write("t3", 8'h3C);
      repeat (12) begin
         check_waiting("t3_wait");
         tick();
      end
      rts_n = 1'b0;
      tick();
      check("t3_sync1_line", serial_data, 1);
      tick();
      check("t3_sync2_line", serial_data, 1);
      tick();
      check_frame("t3", 8'h3C, 1'b1, FRAME_CYC, NONE, 8'h00, 0, 8'h00, NONE);
      check_idle("t3_end");

      // 4: RTS raised in data bit 3 does not disturb the byte; the next one waits
      send_write("t4", 8'h55);
      check_frame("t4", 8'h55, 1'b0, FRAME_CYC, 24, 8'hC3, 0, 8'h00, 17);
      repeat (8) begin
         check_waiting("t4_wait");
         tick();
      end
      rts_n = 1'b0;
      tick();
      check("t4_sync1_line", serial_data, 1);
      tick();
      check("t4_sync2_line", serial_data, 1);
      tick();
      check_frame("t4b", 8'hC3, 1'b0, FRAME_CYC, NONE, 8'h00, 0, 8'h00, NONE);
      check_idle("t4_end");

      // 5: seven back-to-back bytes, frame marker on bytes 0, 3, 6
      send_write("t5", t5_bytes[0]);
      for (int i = 0; i < 7; i++) begin
         check_frame($sformatf("t5_b%0d", i), t5_bytes[i], (i % 3) == 0, FRAME_CYC,
                     (i < 6) ? 10 : NONE, t5_bytes[(i + 1) % 7], 0, 8'h00, NONE);
      end
      check_idle("t5_end");

      // 6: reset in data bit 5 with a byte held, then a fresh byte
      send_write("t6", 8'h5A);
      check_frame("t6", 8'h5A, 1'b0, 26, 10, 8'h77, 0, 8'h00, NONE);
      reset = 1'b1;
      tick();
      check_idle("t6_rst");
      check("t6_rst_new_frame", new_frame, 0);
      reset = 1'b0;
      repeat (3) begin
         tick();
         check_idle("t6_post_rst");
      end
      send_write("t6b", 8'h0F);
      check_frame("t6b", 8'h0F, 1'b1, FRAME_CYC, NONE, 8'h00, 0, 8'h00, NONE);
      check_idle("t6_end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/trng_uart_tx.md
Name: trng_uart_tx

Overview:
Serial transmit stage directly downstream of the TRNG byte FIFO. It accepts one byte per handshake from the FIFO-drain logic and serialises it as 8N1 (or 8N2) UART, least significant bit first. Transmission is gated by the host's active-low RTS at byte boundaries. It also counts bytes into fixed-size frames and pulses a frame marker that drives the board's activity counter.

Parameters:
CLK_DIV, 104, i_clk cycles per serial bit; legal range 2..65535.
FRAME_BYTES, 16, bytes per frame for o_new_frame generation; legal range 1..256.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous active-high reset
i_dat  in  8  byte to transmit
i_write  in  1  write strobe; byte accepted only when o_ready=1
i_serial_rts_n  in  1  host RTS, active low, asynchronous to i_clk
o_ready  out  1  holding register empty; a write is accepted this cycle
o_serial_data  out  1  UART TX line; idles at 1
o_new_frame  out  1  one-cycle pulse when the first byte of a frame starts
o_busy  out  1  shifter not in IDLE

Behaviour:
- Reset: i_reset is synchronous, active-high; clock is i_clk. After reset: o_serial_data=1, o_ready=1, o_new_frame=0, o_busy=0, holding register empty, byte counter=0, baud counter=0, state=IDLE. Both RTS synchroniser flops reset to 1 (not clear to send).
- Reset during a byte aborts it. The line is 1 on the cycle after reset is sampled. Any held byte is discarded.
- RTS: i_serial_rts_n passes through a 2-flop synchroniser. clear_to_send = ~sync2.
- Holding register:
  - i_write & o_ready captures i_dat on the edge; o_ready is 0 from the next cycle.
  - i_write while o_ready=0 is ignored; no overwrite, no error.
  - o_ready returns to 1 on the edge where the shifter loads the byte.
- States: IDLE, WAIT_RTS, START, DATA, STOP.
- IDLE with holding full:
  - If clear_to_send: go to START. On the same edge, load the shifter, empty the holding register, drive the line to 0 and preload the baud counter with CLK_DIV-1.
  - Otherwise go to WAIT_RTS.
- WAIT_RTS: stay until clear_to_send, then behave as the IDLE load. The line stays 1 while waiting.
- Bit timing:
  - Every bit (start, data, stop) lasts exactly CLK_DIV cycles.
  - The baud counter counts down and the bit advances when it reaches 0.
- DATA: shifts out 8 bits, LSB first.
- STOP: drives 1 for STOP_BITS×CLK_DIV cycles, then moves on.
  - If holding is full and clear_to_send: go straight to START. There is no extra idle cycle, so back-to-back bytes give a continuous stream.
  - If holding is full and not clear_to_send: go to WAIT_RTS.
  - Otherwise go to IDLE.
- RTS deassertion inside a byte never aborts or stretches that byte. It only gates the next start bit.
- Latency: with shifter idle and clear_to_send, a write at edge t makes the start bit begin at edge t+1. o_ready is 0 for exactly one cycle.
- Frame counter:
  - Increments on each START entry and wraps from FRAME_BYTES-1 to 0.
  - o_new_frame is registered and high for the one cycle following the START entry at which the counter was 0.
  - With FRAME_BYTES=1, every byte pulses o_new_frame.
- o_busy = (state != IDLE). It is 1 in WAIT_RTS.
- The baud counter width is clog2(CLK_DIV) bits. No other counter wraps except as stated.

Test Plan:
1. CLK_DIV=4, STOP_BITS=1, RTS held low ≥3 cycles, write 0xA5 → line 1 until the edge after the write, then 0 for 4 cycles. Next come bits 1,0,1,0,0,1,0,1, each 4 cycles, then stop 1 for 4 cycles. 40 cycles total; o_ready low exactly 1 cycle.
2. Write 0x01 while shifting, then 0xFF on the next cycle with o_ready=0 → 0xFF is dropped. 0x01's start bit begins the cycle after the previous stop bit ends, with no idle gap.
3. RTS high, write 0x3C → o_busy=1, line stays 1 indefinitely. Drop RTS → start bit begins 3 cycles after the change (2 sync cycles plus the load edge).
4. Raise RTS mid data bit 3 of byte 0x55 → byte completes with unchanged timing. A pending next byte waits in WAIT_RTS until RTS is low again.
5. FRAME_BYTES=3, send 7 bytes back-to-back → o_new_frame pulses on bytes 0, 3 and 6, each pulse 1 cycle wide.
6. Assert reset during data bit 5 with a byte held → the next cycle shows line=1, o_ready=1, o_busy=0. A fresh write afterwards transmits normally and pulses o_new_frame because the counter restarts at 0.
